// File: rtl/traffic_controller_multi_pkg.sv
// Shared lamp codes, phase encoding and round-robin helper for the
// multi-road junction controller.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam int unsigned MAX_ROADS = 8;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_t;

    // First pending side road after last_served, wrapping and skipping road 0.
    function automatic logic [2:0] rr_next(
        input logic [MAX_ROADS-1:0] pending,
        input logic [2:0]           last_served,
        input int unsigned          num_roads
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned cand;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_ROADS; i++) begin
            if (!found && i <= num_roads) begin
                cand = (32'(last_served) + i) % num_roads;
                if (cand != 0 && pending[cand[2:0]]) begin
                    pick  = cand[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Combinational round-robin pick over the side-road requests (roads 1..N-1).
module traffic_rr_arbiter #(
    parameter int unsigned NUM_ROADS = 4
) (
    input  logic [NUM_ROADS-1:1]         side_req,
    input  logic [$clog2(NUM_ROADS)-1:0] last_served,
    output logic [$clog2(NUM_ROADS)-1:0] pick,
    output logic                         valid
);
    import traffic_pkg::*;

    localparam int unsigned RW = $clog2(NUM_ROADS);

    logic [MAX_ROADS-1:0] req_ext;
    logic [2:0]           last_ext;
    logic [2:0]           pick_ext;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_ROADS-1:1]   = side_req;
        last_ext                 = 3'(last_served);
        pick_ext                 = rr_next(req_ext, last_ext, NUM_ROADS);
        pick                     = RW'(pick_ext);
        valid                    = |side_req;
    end

endmodule

// File: rtl/traffic_controller_multi.sv
// Multi-approach junction controller: main road rests on green, side roads
// are served round-robin with main green always interleaved.
module traffic_controller_multi #(
    parameter int unsigned NUM_ROADS      = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned MIN_GREEN      = 10,
    parameter int unsigned YELLOW_TIME    = 3,
    parameter int unsigned ALL_RED_TIME   = 2,
    parameter int unsigned SIDE_MIN_GREEN = 2,
    parameter int unsigned SIDE_MAX_GREEN = 8
) (
    input  logic                         clk,
    input  logic                         start,
    input  logic [NUM_ROADS-1:0]         x,
    output logic [3*NUM_ROADS-1:0]       lights,
    output logic [$clog2(NUM_ROADS)-1:0] green_road,
    output logic [1:0]                   phase
);
    import traffic_pkg::*;

    localparam int unsigned RW = $clog2(NUM_ROADS);

    localparam logic [CNT_W-1:0] T_MAIN      = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] T_YELLOW    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] T_ALL_RED   = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] T_SIDE      = CNT_W'(SIDE_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] T_SIDE_EXIT = CNT_W'(SIDE_MAX_GREEN - SIDE_MIN_GREEN);

    localparam logic [3*NUM_ROADS-1:0] LIGHTS_RST = {{(NUM_ROADS-1){LAMP_RED}}, LAMP_GREEN};

    if (NUM_ROADS < 2 || NUM_ROADS > MAX_ROADS || SIDE_MIN_GREEN > SIDE_MAX_GREEN ||
        MIN_GREEN < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1 || SIDE_MIN_GREEN < 1 ||
        MIN_GREEN > (1 << CNT_W) || SIDE_MAX_GREEN > (1 << CNT_W) ||
        YELLOW_TIME > (1 << CNT_W) || ALL_RED_TIME > (1 << CNT_W)) begin : g_bad_cfg
        $error("traffic_controller_multi: invalid parameter configuration");
    end

    phase_t                 state, state_n;
    logic [RW-1:0]          road_n;
    logic [RW-1:0]          next_road, next_n;
    logic [RW-1:0]          last_served, last_n;
    logic [CNT_W-1:0]       timer, timer_n;
    logic [NUM_ROADS-1:0]   pending, pending_n;
    logic [NUM_ROADS-1:0]   green_mask, pend_eff;
    logic [3*NUM_ROADS-1:0] lights_n;
    logic [RW-1:0]          rr_pick;
    logic                   rr_valid;

    assign phase = state;

    // A road that is currently green never latches its own sensor; road 0 never latches.
    always_comb begin
        green_mask    = '0;
        green_mask[0] = 1'b1;
        if (state == PH_GREEN) green_mask[green_road] = 1'b1;
        pend_eff = pending | (x & ~green_mask);
    end

    traffic_rr_arbiter #(
        .NUM_ROADS (NUM_ROADS)
    ) u_arb (
        .side_req    (pend_eff[NUM_ROADS-1:1]),
        .last_served (last_served),
        .pick        (rr_pick),
        .valid       (rr_valid)
    );

    always_comb begin
        state_n   = state;
        road_n    = green_road;
        next_n    = next_road;
        last_n    = last_served;
        pending_n = pend_eff;
        timer_n   = (timer == '0) ? '0 : timer - 1'b1;

        unique case (state)
            PH_GREEN: begin
                if (green_road == '0) begin
                    if (timer == '0 && rr_valid) begin
                        state_n = PH_YELLOW;
                        timer_n = T_YELLOW;
                        next_n  = rr_pick;
                    end
                end else if (timer == '0 || (!x[green_road] && timer <= T_SIDE_EXIT)) begin
                    state_n = PH_YELLOW;
                    timer_n = T_YELLOW;
                    next_n  = '0;
                end
            end
            PH_YELLOW: begin
                if (timer == '0) begin
                    state_n = PH_ALL_RED;
                    timer_n = T_ALL_RED;
                    road_n  = next_road;
                end
            end
            PH_ALL_RED: begin
                if (timer == '0) begin
                    state_n = PH_GREEN;
                    pending_n[green_road] = 1'b0;
                    if (green_road == '0) begin
                        timer_n = T_MAIN;
                    end else begin
                        timer_n = T_SIDE;
                        last_n  = green_road;
                    end
                end
            end
            default: begin
                state_n = PH_GREEN;
                road_n  = '0;
                timer_n = T_MAIN;
            end
        endcase

        // Lamps are decoded from the next state so they register alongside it.
        lights_n = '0;
        for (int unsigned k = 0; k < NUM_ROADS; k++) begin
            lights_n[3*k +: 3] = LAMP_RED;
            if (road_n == RW'(k)) begin
                if (state_n == PH_GREEN)       lights_n[3*k +: 3] = LAMP_GREEN;
                else if (state_n == PH_YELLOW) lights_n[3*k +: 3] = LAMP_YELLOW;
            end
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state       <= PH_GREEN;
            green_road  <= '0;
            next_road   <= '0;
            last_served <= RW'(NUM_ROADS - 1);
            timer       <= T_MAIN;
            pending     <= '0;
            lights      <= LIGHTS_RST;
        end else begin
            state       <= state_n;
            green_road  <= road_n;
            next_road   <= next_n;
            last_served <= last_n;
            timer       <= timer_n;
            pending     <= pending_n;
            lights      <= lights_n;
        end
    end

endmodule
